booth_mult_param: RTL and testbench

BOOTH_MULT_PARAM -- requirements
Module: booth_mult_param

---
 rtl/booth_mult_param.sv | 133 +++++++++++++
 tb/tb_booth_mult_param.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_param.sv
// ---------------------------------------------------------------------------
// booth_mult_param
// Sequential radix-2 Booth multiplier. Handles signed and unsigned operands
// by extending both operands to WIDTH+1 bits, then doing one Booth step per
// clock cycle for WIDTH+1 cycles.
//
// Ports
//   clk          : clock, rising-edge active
//   rst_n        : asynchronous active-low reset
//   start        : begin a multiplication (sampled only in IDLE)
//   signed_mode  : 1 = two's-complement operands, 0 = unsigned (sampled with start)
//   abort        : cancel an operation in CALC; returns to IDLE with no result
//   multiplicand : M operand, WIDTH bits (sampled with start)
//   multiplier   : Q operand, WIDTH bits (sampled with start)
//   busy         : high in CALC and DONE
//   done         : one-cycle pulse in the cycle product is updated
//   product      : last completed result, 2*WIDTH bits, held until next completion
// ---------------------------------------------------------------------------
module booth_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic                 abort,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int EW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t               state_q, state_d;
  logic [EW-1:0]        a_q, a_d;
  logic [EW-1:0]        q_q, q_d;
  logic [EW-1:0]        m_q, m_d;
  logic                 qm1_q, qm1_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  logic [EW-1:0]        boothSum;
  logic [EW-1:0]        aShift;
  logic [EW-1:0]        qShift;

  // Add/subtract selected by the Booth pair; wraps modulo 2^(WIDTH+1).
  always_comb begin
    boothSum = a_q;
    case ({q_q[0], qm1_q})
      2'b01:   boothSum = a_q + m_q;
      2'b10:   boothSum = a_q - m_q;
      default: boothSum = a_q;
    endcase
  end

  // Arithmetic right shift of {A,Q,q_m1}; the bit leaving Q becomes q_m1.
  assign aShift = {boothSum[EW-1], boothSum[EW-1:1]};
  assign qShift = {boothSum[0], q_q[EW-1:1]};

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    m_d       = m_q;
    qm1_d     = qm1_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          // Sign- or zero-extend by one bit so both modes use the same signed datapath.
          m_d     = {signed_mode & multiplicand[WIDTH-1], multiplicand};
          q_d     = {signed_mode & multiplier[WIDTH-1], multiplier};
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(EW);
          state_d = CALC;
        end
      end
      CALC: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          a_d   = aShift;
          q_d   = qShift;
          qm1_d = q_q[0];
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            // Last step: the low 2*WIDTH bits of the post-shift {A,Q} are the exact result.
            state_d   = DONE;
            product_d = {aShift[WIDTH-2:0], qShift};
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      q_q       <= '0;
      m_q       <= '0;
      qm1_q     <= 1'b0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      m_q       <= m_d;
      qm1_q     <= qm1_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);
  assign product = product_q;

endmodule

// File: tb/tb_booth_mult_param.sv
// ---------------------------------------------------------------------------
// tb_booth_mult_param
// Directed testbench for booth_mult_param. An 8-bit instance carries most
// scenarios; a 5-bit instance covers an odd operand width. Expected values
// are hand-computed constants.
// ---------------------------------------------------------------------------
module tb_booth_mult_param;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start;
  logic        signedMode;
  logic        abort;
  logic [7:0]  mIn;
  logic [7:0]  qIn;
  logic        busy;
  logic        done;
  logic [15:0] product;

  logic        start5;
  logic        signedMode5;
  logic        abort5;
  logic [4:0]  mIn5;
  logic [4:0]  qIn5;
  logic        busy5;
  logic        done5;
  logic [9:0]  product5;

  int vectors    = 0;
  int miscompares = 0;

  booth_mult_param #(.WIDTH(8)) dut8 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .signed_mode  (signedMode),
    .abort        (abort),
    .multiplicand (mIn),
    .multiplier   (qIn),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  booth_mult_param #(.WIDTH(5)) dut5 (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start5),
    .signed_mode  (signedMode5),
    .abort        (abort5),
    .multiplicand (mIn5),
    .multiplier   (qIn5),
    .busy         (busy5),
    .done         (done5),
    .product      (product5)
  );

  always #5 clk = ~clk;

  // Presents one operation to the 8-bit instance in the current cycle and
  // watches a fixed window, reporting the cycle of the first done pulse
  // (0 if none) and how many done cycles were seen.
  task automatic applyStimulus(input logic sm, input logic [7:0] m, input logic [7:0] q,
                               input int window, output int lat, output int nDone);
    lat   = 0;
    nDone = 0;
    signedMode = sm;
    mIn   = m;
    qIn   = q;
    start = 1'b1;
    for (int c = 1; c <= window; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        nDone++;
        if (lat == 0) lat = c;
      end
    end
  endtask

  task automatic test_reset;
    int lat, nDone;
    rst_n = 1'b0;
    start = 1'b0; signedMode = 1'b0; abort = 1'b0; mIn = '0; qIn = '0;
    start5 = 1'b0; signedMode5 = 1'b0; abort5 = 1'b0; mIn5 = '0; qIn5 = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({busy, done, product} !== 18'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state: busy=%b done=%b product=%h, required 0 0 0000", busy, done, product);
    end
    vectors++;
    if ({busy5, done5, product5} !== 12'h0) begin
      miscompares++;
      $display("[TB] FAIL reset_state5: busy=%b done=%b product=%h, required 0 0 000", busy5, done5, product5);
    end
    rst_n = 1'b1;
    // Start is already high when reset releases, so the first edge must accept it.
    applyStimulus(1'b1, 8'h80, 8'h80, 14, lat, nDone);
    vectors++;
    if (product !== 16'h4000) begin
      miscompares++;
      $display("[TB] FAIL signed_min_x_min: product=%h, required 4000", product);
    end
    vectors++;
    if (lat !== 10) begin
      miscompares++;
      $display("[TB] FAIL latency_w8: done at cycle %0d, required 10", lat);
    end
    vectors++;
    if (nDone !== 1) begin
      miscompares++;
      $display("[TB] FAIL done_width: %0d done cycles, required 1", nDone);
    end
  endtask

  task automatic test_unsigned;
    int lat, nDone;
    applyStimulus(1'b0, 8'hFF, 8'hFF, 14, lat, nDone);
    vectors++;
    if (product !== 16'hFE01 || nDone !== 1) begin
      miscompares++;
      $display("[TB] FAIL unsigned_ff_x_ff: product=%h dones=%0d, required FE01 1", product, nDone);
    end
    applyStimulus(1'b0, 8'h00, 8'hFF, 14, lat, nDone);
    vectors++;
    if (product !== 16'h0000 || nDone !== 1) begin
      miscompares++;
      $display("[TB] FAIL unsigned_0_x_ff: product=%h dones=%0d, required 0000 1", product, nDone);
    end
    applyStimulus(1'b0, 8'h80, 8'h80, 14, lat, nDone);
    vectors++;
    if (product !== 16'h4000) begin
      miscompares++;
      $display("[TB] FAIL unsigned_80_x_80: product=%h, required 4000", product);
    end
  endtask

  task automatic test_signed;
    int lat, nDone;
    applyStimulus(1'b1, 8'hFF, 8'hFF, 14, lat, nDone);
    vectors++;
    if (product !== 16'h0001) begin
      miscompares++;
      $display("[TB] FAIL signed_m1_x_m1: product=%h, required 0001", product);
    end
    applyStimulus(1'b1, 8'h7F, 8'h80, 14, lat, nDone);
    vectors++;
    if (product !== 16'hC080) begin
      miscompares++;
      $display("[TB] FAIL signed_127_x_m128: product=%h, required C080", product);
    end
  endtask

  task automatic test_width5;
    int lat = 0;
    int nDone = 0;
    signedMode5 = 1'b1;
    mIn5 = 5'b10110;
    qIn5 = 5'b01101;
    start5 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge clk); #1;
      start5 = 1'b0;
      if (done5) begin
        nDone++;
        if (lat == 0) lat = c;
      end
    end
    vectors++;
    if (product5 !== 10'b1101111110) begin
      miscompares++;
      $display("[TB] FAIL w5_m10_x_13: product=%b, required 1101111110", product5);
    end
    vectors++;
    if (lat !== 7 || nDone !== 1) begin
      miscompares++;
      $display("[TB] FAIL latency_w5: done at cycle %0d (%0d pulses), required 7 (1)", lat, nDone);
    end
  endtask

  // A second start during CALC must be ignored; the first operands finish.
  task automatic test_restart_ignored;
    int nDone = 0;
    int busyDrops = 0;
    signedMode = 1'b1; mIn = 8'd5; qIn = 8'hFD; start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (c == 3) begin
        mIn = 8'd9; qIn = 8'd9; start = 1'b1;
      end
      if (c <= 10 && !busy) busyDrops++;
      if (done) nDone++;
    end
    vectors++;
    if (product !== 16'hFFF1) begin
      miscompares++;
      $display("[TB] FAIL restart_product: product=%h, required FFF1", product);
    end
    vectors++;
    if (nDone !== 1) begin
      miscompares++;
      $display("[TB] FAIL restart_done_count: %0d, required 1", nDone);
    end
    vectors++;
    if (busyDrops !== 0) begin
      miscompares++;
      $display("[TB] FAIL restart_busy: busy low in %0d cycles, required 0", busyDrops);
    end
  endtask

  task automatic test_reset_mid_calc;
    int lat, nDone;
    int quietDones = 0;
    signedMode = 1'b0; mIn = 8'd3; qIn = 8'd5; start = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (product !== 16'h0000 || busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_mid_calc: product=%h busy=%b, required 0000 0", product, busy);
    end
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;
    for (int c = 0; c < 14; c++) begin
      if (done) quietDones++;
      @(posedge clk); #1;
    end
    vectors++;
    if (quietDones !== 0 || product !== 16'h0000) begin
      miscompares++;
      $display("[TB] FAIL reset_no_stale: dones=%0d product=%h, required 0 0000", quietDones, product);
    end
    applyStimulus(1'b0, 8'd7, 8'd6, 14, lat, nDone);
    vectors++;
    if (product !== 16'h002A || nDone !== 1) begin
      miscompares++;
      $display("[TB] FAIL after_reset_7x6: product=%h dones=%0d, required 002A 1", product, nDone);
    end
  endtask

  task automatic test_abort;
    int nDone = 0;
    signedMode = 1'b0; mIn = 8'd3; qIn = 8'd3; start = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
    end
    // Start is raised together with abort; abort must win.
    abort = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    start = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL abort_to_idle: busy=%b, required 0", busy);
    end
    for (int c = 0; c < 14; c++) begin
      if (done) nDone++;
      @(posedge clk); #1;
    end
    vectors++;
    if (nDone !== 0 || product !== 16'h002A) begin
      miscompares++;
      $display("[TB] FAIL abort_holds_product: dones=%0d product=%h, required 0 002A", nDone, product);
    end
  endtask

  // With start held high, results arrive every WIDTH+3 cycles.
  task automatic test_back_to_back;
    int first = 0;
    int second = 0;
    signedMode = 1'b0; mIn = 8'd2; qIn = 8'd3; start = 1'b1;
    for (int c = 1; c <= 30 && second == 0; c++) begin
      @(posedge clk); #1;
      if (done) begin
        if (first == 0) first = c;
        else second = c;
      end
    end
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    vectors++;
    if (first !== 10 || second !== 21) begin
      miscompares++;
      $display("[TB] FAIL back_to_back: done at %0d and %0d, required 10 and 21", first, second);
    end
    vectors++;
    if (product !== 16'h0006) begin
      miscompares++;
      $display("[TB] FAIL back_to_back_product: product=%h, required 0006", product);
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_width5();
    test_restart_ignored();
    test_reset_mid_calc();
    test_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
